// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the UART transmit scheduler.
//  Contents : BYTE_W       - width of one serialized byte
//             sched_state_t - scheduler FSM state encoding
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_sched_if
//  Purpose  : Bundles the requester-side byte handshakes and the uart_tx
//             start/done handshake of the transmit scheduler.
//  Ports    : req_valid/req_data/req_last/req_ready - per-requester handshake
//             tx_valid/tx_data/tx_busy/tx_done      - serializer handshake
//  Modports : slave  - the scheduler
//             master - the environment (requesters + serializer)
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_sched_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_valid;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_busy;
    logic                      tx_done;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy, tx_done,
        output req_ready, tx_valid, tx_data
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy, tx_done,
        input  req_ready, tx_valid, tx_data
    );

endinterface : uart_tx_sched_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick: the first set request bit at or
//             after ptr, searching cyclically.
//  Ports    : req   in  N          request vector
//             ptr   in  $clog2(N)  highest-priority position
//             grant out N          one-hot winner (zero when none)
//             idx   out $clog2(N)  index of the winner
//             any   out 1          at least one request present
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  wire logic [N-1:0]         req,
    input  wire logic [$clog2(N)-1:0] ptr,
    output logic      [N-1:0]         grant,
    output logic      [$clog2(N)-1:0] idx,
    output logic                      any
);

    localparam int W = $clog2(N);

    // One extra bit so ptr + offset can be folded back below N for
    // non-power-of-two N.
    logic [W:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (W+1)'(i);
            if (pos >= (W+1)'(N)) begin
                pos = pos - (W+1)'(N);
            end
            if (!any && req[pos[W-1:0]]) begin
                any                = 1'b1;
                grant[pos[W-1:0]]  = 1'b1;
                idx                = pos[W-1:0];
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_sched
//  Purpose  : Burst-locked round-robin scheduler sharing one uart_tx among
//             NUM_REQ byte-stream requesters. A grant is held until a byte
//             flagged last has completed, or revoked after GAP_TIMEOUT idle
//             cycles mid-burst.
//  Ports    : clk, rst_n    clock / asynchronous active-low reset
//             bus           requester and serializer handshakes (slave)
//             grant_id      current or last granted requester
//             grant_active  a burst is locked
//             burst_abort   one-cycle pulse on gap-timeout revocation
//             byte_count    completed bytes, wraps modulo 2^CNT_W
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int GAP_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    uart_tx_sched_if.slave                  bus,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            grant_active,
    output logic                            burst_abort,
    output logic [CNT_W-1:0]                byte_count
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_TIMEOUT);

    sched_state_t       state_q,        state_d;
    logic [IDX_W-1:0]   rr_ptr_q,       rr_ptr_d;
    logic [IDX_W-1:0]   grant_id_q,     grant_id_d;
    logic [NUM_REQ-1:0] grant_oh_q,     grant_oh_d;
    logic               grant_active_q, grant_active_d;
    logic               tx_valid_q,     tx_valid_d;
    logic               burst_abort_q,  burst_abort_d;
    logic               last_q,         last_d;
    logic [BYTE_W-1:0]  tx_data_q,      tx_data_d;
    logic [GAP_W-1:0]   gap_q,          gap_d;
    logic [CNT_W-1:0]   byte_count_q,   byte_count_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [BYTE_W-1:0]  sel_data;
    logic               sel_last;
    logic               handshake;
    logic [IDX_W-1:0]   next_ptr;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Ready depends only on state and the held grant, never on req_valid.
    assign bus.req_ready = (state_q == SEND) ? grant_oh_q : '0;
    assign handshake     = |(bus.req_valid & bus.req_ready);
    assign next_ptr      = (grant_id_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh_q[i]) begin
                sel_data = bus.req_data[i*BYTE_W +: BYTE_W];
                sel_last = bus.req_last[i];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        grant_oh_d     = grant_oh_q;
        grant_active_d = grant_active_q;
        tx_valid_d     = 1'b0;
        burst_abort_d  = 1'b0;
        last_d         = last_q;
        tx_data_d      = tx_data_q;
        gap_d          = gap_q;
        byte_count_d   = byte_count_q;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_id_d     = arb_idx;
                    grant_oh_d     = arb_grant;
                    grant_active_d = 1'b1;
                    gap_d          = '0;
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    tx_data_d  = sel_data;
                    last_d     = sel_last;
                    // Pulse immediately if the serializer is free, else
                    // ISSUE holds with tx_valid low until it is.
                    tx_valid_d = !bus.tx_busy;
                    state_d    = ISSUE;
                end else if (gap_q == GAP_W'(GAP_TIMEOUT-1)) begin
                    burst_abort_d  = 1'b1;
                    grant_active_d = 1'b0;
                    rr_ptr_d       = next_ptr;
                    state_d        = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ISSUE: begin
                if (tx_valid_q) begin
                    state_d = WAIT_DONE;
                end else if (!bus.tx_busy) begin
                    tx_valid_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    byte_count_d = byte_count_q + 1'b1;
                    if (last_q) begin
                        grant_active_d = 1'b0;
                        rr_ptr_d       = next_ptr;
                        state_d        = IDLE;
                    end else begin
                        gap_d   = '0;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            grant_oh_q     <= '0;
            grant_active_q <= 1'b0;
            tx_valid_q     <= 1'b0;
            burst_abort_q  <= 1'b0;
            last_q         <= 1'b0;
            tx_data_q      <= '0;
            gap_q          <= '0;
            byte_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            grant_oh_q     <= grant_oh_d;
            grant_active_q <= grant_active_d;
            tx_valid_q     <= tx_valid_d;
            burst_abort_q  <= burst_abort_d;
            last_q         <= last_d;
            tx_data_q      <= tx_data_d;
            gap_q          <= gap_d;
            byte_count_q   <= byte_count_d;
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;
    assign burst_abort  = burst_abort_q;
    assign byte_count   = byte_count_q;

endmodule : uart_tx_sched
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_sched
//  Purpose  : Self-checking bench for uart_tx_sched with a behavioural
//             8-clocks-per-bit serializer and per-requester byte sources.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam int NUM_REQ = 4;
    localparam int GAP     = 64;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       grant_id;
    logic             grant_active;
    logic             burst_abort;
    logic [CNT_W-1:0] byte_count;

    uart_tx_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_sched #(
        .NUM_REQ     (NUM_REQ),
        .GAP_TIMEOUT (GAP),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .burst_abort  (burst_abort),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- serializer model (CLKS_PER_BIT = 8) ----------------
    logic       u_busy, u_done;
    logic [9:0] u_frame;
    logic [3:0] u_bit;
    logic [2:0] u_cnt;
    logic       txd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_busy <= 1'b0; u_done <= 1'b0; u_frame <= '1; u_bit <= '0; u_cnt <= '0;
        end else begin
            u_done <= 1'b0;
            if (!u_busy) begin
                if (bus.tx_valid) begin
                    u_busy  <= 1'b1;
                    u_frame <= {1'b1, bus.tx_data, 1'b0};
                    u_bit   <= '0;
                    u_cnt   <= '0;
                end
            end else if (u_cnt == 3'd7) begin
                u_cnt <= '0;
                if (u_bit == 4'd9) begin
                    u_busy <= 1'b0;
                    u_done <= 1'b1;
                end else begin
                    u_bit <= u_bit + 1'b1;
                end
            end else begin
                u_cnt <= u_cnt + 1'b1;
            end
        end
    end

    assign txd         = u_busy ? u_frame[u_bit] : 1'b1;
    assign bus.tx_busy = u_busy;
    assign bus.tx_done = u_done;

    // ---------------- requester sources ----------------
    logic [8:0] src_q [NUM_REQ][$];   // {last, byte}
    bit         hs_seen [NUM_REQ];
    logic [NUM_REQ-1:0]   drv_valid, drv_last;
    logic [NUM_REQ*8-1:0] drv_data;

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
    end

    always @(posedge clk) begin
        #1;
        drv_valid = '0; drv_last = '0; drv_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                drv_valid[i]       = 1'b1;
                drv_data[i*8 +: 8] = src_q[i][0][7:0];
                drv_last[i]        = src_q[i][0][8];
            end
        end
        bus.req_valid = drv_valid;
        bus.req_data  = drv_data;
        bus.req_last  = drv_last;
    end

    // ---------------- scoreboard monitor ----------------
    logic [9:0] exp_q [$];            // {grant_id, byte}
    logic [9:0] exp_e;
    int         tx_count = 0;
    int         abort_cnt = 0;
    logic [CNT_W-1:0] bc_at_abort;
    logic             ga_at_abort;

    always @(negedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) hs_seen[i] = bus.req_valid[i] & bus.req_ready[i];
        if (rst_n && bus.tx_valid) begin
            tx_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got id=%0d data=%02h, required none", grant_id, bus.tx_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({grant_id, bus.tx_data} !== exp_e) begin
                    errors++;
                    $display("FAIL tx_byte: got id=%0d data=%02h, required id=%0d data=%02h",
                             grant_id, bus.tx_data, exp_e[9:8], exp_e[7:0]);
                end
            end
        end
        if (rst_n && burst_abort) begin
            abort_cnt++;
            bc_at_abort = byte_count;
            ga_at_abort = grant_active;
        end
    end

    // ---------------- helpers ----------------
    task automatic push(input int id, input logic [7:0] b, input logic last);
        src_q[id].push_back({last, b});
        exp_q.push_back({2'(id), b});
    endtask

    function automatic bit drained();
        bit e = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e && exp_q.size() == 0 && !grant_active && !u_busy;
    endfunction

    task automatic wait_drain(input int maxc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (drained()) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({grant_active, bus.tx_valid, burst_abort, bus.req_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ga=%b txv=%b abort=%b ready=%b, required all 0",
                     grant_active, bus.tx_valid, burst_abort, bus.req_ready);
        end
        checks++;
        if ({grant_id, bus.tx_data, byte_count} !== 14'b0) begin
            errors++;
            $display("FAIL reset_data: got id=%0d data=%02h cnt=%0d, required 0/00/0",
                     grant_id, bus.tx_data, byte_count);
        end
        do_reset();
    endtask

    task automatic test_single_byte();
        bit ok;
        int start;
        logic [9:0] frame;
        logic [9:0] exp_frame;
        start = tx_count;
        push(0, 8'hA5, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            if (tx_count != start) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_txvalid: got no tx_valid, required one within 50 cycles");
        end
        repeat (4) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            frame[k] = txd;
            if (k < 9) repeat (8) @(negedge clk);
        end
        exp_frame = {1'b1, 8'hA5, 1'b0};
        checks++;
        if (frame !== exp_frame) begin
            errors++;
            $display("FAIL single_line: got frame=%b, required %b", frame, exp_frame);
        end
        wait_drain(200, ok);
        checks++;
        if (!ok || byte_count !== 4'd1 || grant_active !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got drained=%b cnt=%0d ga=%b, required 1/1/0", ok, byte_count, grant_active);
        end
    endtask

    task automatic test_locked_burst();
        bit ok;
        int viol;
        logic [CNT_W-1:0] base, diff;
        base = byte_count;
        viol = 0;
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        push(2, 8'h44, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            diff = byte_count - base;
            if (bus.req_ready[2] && diff < 4'd3) viol++;
            if (drained()) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL locked_drain: got timeout, required all four bytes sent");
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL locked_ready2: got %0d early ready cycles, required 0", viol);
        end
        checks++;
        if (byte_count !== base + 4'd4) begin
            errors++;
            $display("FAIL locked_count: got %0d, required %0d", byte_count, base + 4'd4);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        exp_q.delete();
        push(0, 8'hA0, 1'b1);
        push(2, 8'hC0, 1'b1);
        push(3, 8'hD0, 1'b1);
        push(0, 8'hA1, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_drain(1000, ok);
        checks++;
        if (!ok || byte_count !== 4'd4) begin
            errors++;
            $display("FAIL rr_done: got drained=%b cnt=%0d, required 1/4", ok, byte_count);
        end
    endtask

    task automatic test_gap_timeout();
        bit ok;
        do_reset();
        abort_cnt = 0;
        push(1, 8'h55, 1'b0);
        push(3, 8'h77, 1'b1);
        wait_drain(1000, ok);
        checks++;
        if (!ok || abort_cnt != 1) begin
            errors++;
            $display("FAIL gap_abort: got drained=%b aborts=%0d, required 1/1", ok, abort_cnt);
        end
        checks++;
        if (ga_at_abort !== 1'b0 || bc_at_abort !== 4'd1) begin
            errors++;
            $display("FAIL gap_state: got ga=%b cnt=%0d at abort, required 0/1", ga_at_abort, bc_at_abort);
        end
        checks++;
        if (byte_count !== 4'd2) begin
            errors++;
            $display("FAIL gap_count: got %0d, required 2", byte_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int start;
        start = tx_count;
        push(2, 8'h99, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            if (tx_count != start) begin ok = 1'b1; break; end
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {grant_active, bus.tx_valid, burst_abort, bus.req_ready} !== 7'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: got seen=%b ga=%b txv=%b abort=%b ready=%b, required 1/0/0/0/0",
                     ok, grant_active, bus.tx_valid, burst_abort, bus.req_ready);
        end
        checks++;
        if ({grant_id, bus.tx_data, byte_count} !== 14'b0) begin
            errors++;
            $display("FAIL midrst_data: got id=%0d data=%02h cnt=%0d, required 0/00/0",
                     grant_id, bus.tx_data, byte_count);
        end
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        exp_q.delete();
        push(3, 8'h3C, 1'b1);
        src_q[0].push_front({1'b1, 8'h5A});
        exp_q.push_front({2'd0, 8'h5A});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_drain(1000, ok);
        checks++;
        if (!ok || byte_count !== 4'd2) begin
            errors++;
            $display("FAIL midrst_after: got drained=%b cnt=%0d, required 1/2", ok, byte_count);
        end
    endtask

    task automatic test_counter_wrap();
        bit ok;
        do_reset();
        for (int k = 0; k < 17; k++) push(1, 8'(8'h60 + k), (k == 16));
        wait_drain(3000, ok);
        checks++;
        if (!ok || byte_count !== 4'd1) begin
            errors++;
            $display("FAIL wrap_count: got drained=%b cnt=%0d, required 1/1", ok, byte_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_locked_burst();
        test_round_robin();
        test_gap_timeout();
        test_reset_mid_frame();
        test_counter_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending bytes, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx_sched
`default_nettype wire
